// File: rtl/serial_work_transmit_pkg.sv
// Shared constants and FSM encoding for the serial work-unit link.
// The receiving end uses the same frame size so both sides agree on framing.
package serial_work_transmit_pkg;

  localparam int unsigned FRAME_BITS = 512;
  localparam int unsigned BYTES      = 64;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StArm,
    StWait,
    StGap,
    StNext
  } tx_state_e;

endpackage

// File: rtl/async_transmitter.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
// TxD_busy rises the cycle after TxD_start is taken and falls after the stop bit.
module async_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       TxD_busy
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  logic             busy_q, busy_d;
  logic             tx_q, tx_d;
  logic [8:0]       sh_q, sh_d;
  logic [3:0]       bit_q, bit_d;
  logic [BaudW-1:0] baud_q, baud_d;

  always_comb begin
    busy_d = busy_q;
    tx_d   = tx_q;
    sh_d   = sh_q;
    bit_d  = bit_q;
    baud_d = baud_q;
    if (!busy_q) begin
      if (TxD_start) begin
        busy_d = 1'b1;
        sh_d   = {1'b1, TxD_data};
        tx_d   = 1'b0;
        bit_d  = 4'd0;
        baud_d = '0;
      end
    end else if (baud_q == BaudLast) begin
      baud_d = '0;
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
        tx_d   = 1'b1;
      end else begin
        // sh_q holds the remaining data bits followed by the stop bit
        tx_d  = sh_q[0];
        sh_d  = {1'b1, sh_q[8:1]};
        bit_d = bit_q + 4'd1;
      end
    end else begin
      baud_d = baud_q + BaudW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      tx_q   <= 1'b1;
      sh_q   <= '0;
      bit_q  <= '0;
      baud_q <= '0;
    end else begin
      busy_q <= busy_d;
      tx_q   <= tx_d;
      sh_q   <= sh_d;
      bit_q  <= bit_d;
      baud_q <= baud_d;
    end
  end

  assign TxD      = tx_q;
  assign TxD_busy = busy_q;

endmodule

// File: rtl/serial_work_transmit.sv
// Sends {midstate, data2} as 64 UART bytes, most significant byte first,
// with an optional idle gap after every byte.
module serial_work_transmit
  import serial_work_transmit_pkg::*;
#(
  parameter int unsigned BYTES        = serial_work_transmit_pkg::BYTES,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         send,
  input  logic [255:0] midstate,
  input  logic [255:0] data2,
  output logic         busy,
  output logic         done,
  output logic         TxD
);

  localparam int unsigned CntW    = $clog2(BYTES + 1);
  localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  tx_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [GapW-1:0]       gap_q, gap_d;

  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    tx_start = 1'b0;
    tx_data  = shift_q[FRAME_BITS-1 -: 8];
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (send) begin
          shift_d = {midstate, data2};
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          shift_d  = {shift_q[FRAME_BITS-9:0], 8'h00};
          cnt_d    = cnt_q + CntW'(1);
          state_d  = StArm;
        end
      end
      // Transmitter raises TxD_busy one cycle after the start strobe.
      StArm: state_d = StWait;
      StWait: begin
        if (!tx_busy) begin
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? StNext : StGap;
        end
      end
      StGap: begin
        if (gap_q == GapW'(GapLast)) begin
          state_d = StNext;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StNext: begin
        if (cnt_q == CntW'(BYTES)) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StStart;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  assign busy = (state_q != StIdle);

  async_transmitter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .reset    (reset),
    .TxD_start(tx_start),
    .TxD_data (tx_data),
    .TxD      (TxD),
    .TxD_busy (tx_busy)
  );

endmodule

// File: tb/tb_serial_work_transmit.sv
// Bench for serial_work_transmit: a UART line decoder collects bytes, which are
// compared against the frame split into bytes most significant first.
module tb_serial_work_transmit;

  localparam int CPB = 4;
  localparam int GAP = 1;
  localparam int NB  = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         send = 1'b0;
  logic [255:0] midstate = '0;
  logic [255:0] data2 = '0;
  logic         busy, done, TxD;

  always #5 clk = ~clk;

  serial_work_transmit #(
    .BYTES       (NB),
    .GAP_CYCLES  (GAP),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .send    (send),
    .midstate(midstate),
    .data2   (data2),
    .busy    (busy),
    .done    (done),
    .TxD     (TxD)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  int done_cnt = 0, done_long = 0, start_cnt = 0, start_bad = 0, framing_err = 0;

  typedef struct {
    string        name;
    logic [255:0] mid;
    logic [255:0] d2;
    logic [7:0]   first_b;
    logic [7:0]   last_b;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Frame byte i, 0 = first on the line.
  function automatic logic [7:0] model_byte(input logic [511:0] w, input int i);
    return w[8*(NB-1-i) +: 8];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic int rx_at(input int idx);
    if (idx < 0 || idx >= rx_q.size()) return -1;
    return int'(rx_q[idx]);
  endfunction

  // UART decoder, sampling mid-bit on negative edges.
  initial begin
    bit         active = 1'b0;
    int         cnt = 0;
    logic [7:0] sh = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0;
      end else if (!active) begin
        if (TxD == 1'b0) begin
          active = 1'b1;
          cnt    = 0;
        end
      end else begin
        cnt++;
        if (cnt % CPB == CPB / 2) begin
          if (cnt / CPB >= 1 && cnt / CPB <= 8) sh[cnt/CPB-1] = TxD;
          if (cnt / CPB == 9) begin
            if (TxD !== 1'b1) framing_err++;
            rx_q.push_back(sh);
            active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    bit prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (done && prev_done) done_long++;
      prev_done = done;
      if (dut.tx_start) start_cnt++;
      if (dut.tx_start && dut.tx_busy) start_bad++;
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, 64'(done), 64'd1);
  endtask

  task automatic compare_stream(input string name, input int base, input int nw,
                                input logic [511:0] w0, input logic [511:0] w1);
    int bad = 0;
    check({name, "_byte_count"}, 64'(rx_q.size() - base), 64'(nw * NB));
    for (int i = 0; i < nw * NB; i++) begin
      if (rx_at(base + i) != int'(model_byte((i < NB) ? w0 : w1, i % NB))) bad++;
    end
    check({name, "_bad_bytes"}, 64'(bad), 64'd0);
  endtask

  // Caller is at a negative edge with the DUT idle.
  task automatic run_frame(input string name, input logic [255:0] m, input logic [255:0] d,
                           output int base);
    int d0, s0;
    base = rx_q.size();
    d0 = done_cnt;
    s0 = start_cnt;
    midstate = m;
    data2 = d;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check({name, "_busy_after_send"}, 64'(busy), 64'd1);
    wait_done(name);
    check({name, "_busy_at_done"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({name, "_busy_after_done"}, 64'(busy), 64'd0);
    check({name, "_done_one_cycle"}, 64'(done), 64'd0);
    repeat (4) @(negedge clk);
    compare_stream(name, base, 1, {m, d}, '0);
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_start_pulses"}, 64'(start_cnt - s0), 64'(NB));
  endtask

  initial begin
    int base, bad, d0, s0, n;
    logic [255:0] a_m, a_d, b_m, b_d, w1_m, w1_d, w2_m, w2_d;

    vecs[0].name = "incr";
    for (int i = 0; i < 32; i++) begin
      vecs[0].mid[255-8*i -: 8] = 8'(i);
      vecs[0].d2[255-8*i -: 8]  = 8'(32 + i);
    end
    vecs[0].first_b = 8'h00;
    vecs[0].last_b  = 8'h3f;
    vecs[1] = '{"ones", {256{1'b1}}, {256{1'b1}}, 8'hff, 8'hff};
    vecs[2] = '{"a5_5a", {32{8'ha5}}, {32{8'h5a}}, 8'ha5, 8'h5a};
    vecs[3].name = "rand";
    vecs[3].mid  = rand256();
    vecs[3].d2   = rand256();
    vecs[3].first_b = vecs[3].mid[255:248];
    vecs[3].last_b  = vecs[3].d2[7:0];

    // Reset state
    @(negedge clk);
    check("reset_txd", 64'(TxD), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Idle for 1000 cycles
    bad = 0;
    s0 = start_cnt;
    repeat (1000) begin
      @(negedge clk);
      if (TxD !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_bad_cycles", 64'(bad), 64'd0);
    check("idle_starts", 64'(start_cnt - s0), 64'd0);
    check("idle_bytes", 64'(rx_q.size()), 64'd0);

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].name, vecs[v].mid, vecs[v].d2, base);
      check({vecs[v].name, "_first"}, 64'(rx_at(base)), 64'(vecs[v].first_b));
      check({vecs[v].name, "_last"}, 64'(rx_at(base + NB - 1)), 64'(vecs[v].last_b));
    end

    run_frame("rand2", rand256(), rand256(), base);

    // send pulsed again mid-frame with different data is ignored
    a_m = rand256();
    a_d = rand256();
    b_m = ~a_m;
    b_d = ~a_d;
    base = rx_q.size();
    d0 = done_cnt;
    midstate = a_m;
    data2 = a_d;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (300) @(negedge clk);
    midstate = b_m;
    data2 = b_d;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    wait_done("midsend");
    repeat (60) @(negedge clk);
    check("midsend_busy_after", 64'(busy), 64'd0);
    compare_stream("midsend", base, 1, {a_m, a_d}, '0);
    check("midsend_done_pulses", 64'(done_cnt - d0), 64'd1);

    // send held high: two back-to-back frames
    w1_m = rand256();
    w1_d = rand256();
    w2_m = rand256();
    w2_d = rand256();
    base = rx_q.size();
    d0 = done_cnt;
    s0 = start_cnt;
    midstate = w1_m;
    data2 = w1_d;
    send = 1'b1;
    @(negedge clk);
    wait_done("held1");
    midstate = w2_m;
    data2 = w2_d;
    @(negedge clk);
    check("held_idle_cycle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("held_second_accept", 64'(busy), 64'd1);
    send = 1'b0;
    wait_done("held2");
    repeat (5) @(negedge clk);
    compare_stream("held", base, 2, {w1_m, w1_d}, {w2_m, w2_d});
    check("held_done_pulses", 64'(done_cnt - d0), 64'd2);
    check("held_start_pulses", 64'(start_cnt - s0), 64'(2 * NB));

    // Reset after byte 10 aborts; a new frame then goes out whole
    base = rx_q.size();
    midstate = rand256();
    data2 = rand256();
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    n = 0;
    while (rx_q.size() < base + 10 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_byte10", 64'(rx_q.size() >= base + 10), 64'd1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_txd", 64'(TxD), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_frame("after_abort", rand256(), rand256(), base);

    check("framing_errors", 64'(framing_err), 64'd0);
    check("start_while_busy", 64'(start_bad), 64'd0);
    check("done_longer_than_one", 64'(done_long), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
